fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Sequences one shared combinational butterfly unit through a full in-place radix-2 DIT FFT of SAMPLES points.
- Sample memory is an external dual-port synchronous RAM with 1-cycle read latency. Input data is preloaded in bit-reversed order. The twiddle ROM is external.
- Per butterfly, the block generates the A/B read addresses, the twiddle address and the writeback addresses, and routes RAM data to and from the butterfly.
- Throughput is one butterfly per cycle, with one drain cycle per stage.

Parameters:
- SAMPLES, 8: FFT points. Power of two, ≥4.
- WIDTH, 16: packed complex word. Imag in [WIDTH-1:WIDTH/2], real in [WIDTH/2-1:0], each half two's complement.
- LOG2 (localparam): $clog2(SAMPLES). Equals the stage count and the address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse at completion
- rd_addr_a  out  LOG2  RAM port A read address
- rd_addr_b  out  LOG2  RAM port B read address
- rd_data_a  in  WIDTH  port A data, valid 1 cycle after address
- rd_data_b  in  WIDTH  port B data, valid 1 cycle after address
- tw_addr  out  LOG2-1  twiddle ROM address (1-cycle latency)
- tw_data  in  WIDTH  twiddle word
- bf_in1  out  WIDTH  butterfly input1; equals rd_data_a
- bf_in2  out  WIDTH  butterfly input2; equals rd_data_b
- bf_tw  out  WIDTH  butterfly twiddle; equals tw_data
- bf_out1  in  WIDTH  butterfly output1
- bf_out2  in  WIDTH  butterfly output2
- wr_en  out  1  write both RAM ports
- wr_addr_a  out  LOG2  write address for wr_data_a
- wr_addr_b  out  LOG2  write address for wr_data_b
- wr_data_a  out  WIDTH  from bf_out1
- wr_data_b  out  WIDTH  from bf_out2

Behaviour:
- Reset (asynchronous, rst_n low):
  - State returns to IDLE; stage and butterfly counters clear.
  - All registered outputs go to 0: busy, done, wr_en, rd_addr_a/b, tw_addr, wr_addr_a/b.
  - Reset mid-transform aborts immediately. RAM contents are left as-is (undefined result). No done pulse is produced.
- States:
  - IDLE: start=1 → RUN, with stage s=0 and butterfly k=0.
  - RUN: issue butterfly (s,k) each cycle. If k=SAMPLES/2-1 → DRAIN; else k++.
  - DRAIN: single bubble so the last write of stage s lands before stage s+1 reads. If s=LOG2-1 → DONE; else s++, k=0, → RUN.
  - DONE: done=1 for one cycle → IDLE.
- Address generation (registered, issued in RUN):
  - span = 2^s, grp = k>>s, pos = k & (span-1)
  - rd_addr_a = grp·2·span + pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << (LOG2-1-s)
- Writeback pipeline:
  - Issue-valid, rd_addr_a and rd_addr_b are delayed one cycle into wr_en, wr_addr_a and wr_addr_b.
  - The write occurs in the cycle the read data is valid (butterfly is combinational).
  - wr_en is high exactly SAMPLES/2 cycles per stage: in the RUN cycles after the first of the stage, plus DRAIN.
- Hazards: none within a stage, since each address is touched once. Across stages, the DRAIN bubble guarantees write-before-read. The RAM must return new data on a read issued the cycle after a write.
- Latency: busy high for LOG2·(SAMPLES/2+1) cycles. done is asserted the following cycle. For SAMPLES=8: 15 busy cycles, done on cycle 16 after the start edge.
- Other rules:
  - start while busy or in DONE is ignored.
  - start held high in IDLE after DONE begins a new transform.
  - Counters never wrap beyond their terminal values.
  - rd_addr and tw_addr hold their last value outside RUN and are don't-care there.

Optional Feature:
- Macro: FFT_SCALE_EN.
- Defined: wr_data_a and wr_data_b are bf_out1 and bf_out2 with each WIDTH/2 half arithmetic-shifted right by 1 (sign-preserving, truncating). This gives a total 1/SAMPLES scaling and prevents overflow.
- Undefined: wr_data equals bf_out unmodified.

Test Plan:
- Reset: rst_n low with start=1 → all outputs 0, no busy. Release rst_n → RUN entered on the first edge with start=1.
- Address sequence, SAMPLES=8: (a,b,tw) per cycle must be:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - One DRAIN cycle with no read issue between stages.
- Writeback timing: each wr_en/wr_addr pair must equal the read pair issued one cycle earlier. busy is high for exactly 15 cycles, followed by a single done pulse.
- Impulse with behavioural RAM and butterfly: x[0]=16'h0040, others 0, arbitrary twiddles → all 8 final words 16'h0040. With FFT_SCALE_EN, all words 16'h0008.
- start asserted during busy and during DONE → ignored; sequence and done timing unchanged.
- rst_n pulsed low mid-stage 1 → outputs 0 immediately, no done. A subsequent start runs a full clean 15-cycle sequence.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage/butterfly sequencer driving a shared combinational butterfly.
// Optional FFT_SCALE_EN: halve each real/imag half on writeback (1/SAMPLES overall scaling).
module fft_stage_sequencer #(
    parameter int unsigned SAMPLES = 8,
    parameter int unsigned WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(SAMPLES)-1:0]   rd_addr_a,
    output logic [$clog2(SAMPLES)-1:0]   rd_addr_b,
    input  logic [WIDTH-1:0]             rd_data_a,
    input  logic [WIDTH-1:0]             rd_data_b,
    output logic [$clog2(SAMPLES)-2:0]   tw_addr,
    input  logic [WIDTH-1:0]             tw_data,
    output logic [WIDTH-1:0]             bf_in1,
    output logic [WIDTH-1:0]             bf_in2,
    output logic [WIDTH-1:0]             bf_tw,
    input  logic [WIDTH-1:0]             bf_out1,
    input  logic [WIDTH-1:0]             bf_out2,
    output logic                         wr_en,
    output logic [$clog2(SAMPLES)-1:0]   wr_addr_a,
    output logic [$clog2(SAMPLES)-1:0]   wr_addr_b,
    output logic [WIDTH-1:0]             wr_data_a,
    output logic [WIDTH-1:0]             wr_data_b
);

    localparam int unsigned LOG2 = $clog2(SAMPLES);
    localparam int unsigned HALF = SAMPLES / 2;
    localparam int unsigned KW   = LOG2 - 1;
    localparam int unsigned SW   = (LOG2 > 1) ? $clog2(LOG2) : 1;
    localparam int unsigned HW   = WIDTH / 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [KW-1:0]   bfly_q, bfly_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_en_q, wr_en_d;
    logic [LOG2-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [LOG2-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]   tw_addr_q, tw_addr_d;
    logic [LOG2-1:0] wr_addr_a_q, wr_addr_a_d;
    logic [LOG2-1:0] wr_addr_b_q, wr_addr_b_d;

    logic [LOG2-1:0] span, pos, grp, addr_a;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            StRun: begin
                if (bfly_q == KW'(HALF - 1)) begin
                    state_d = StDrain;
                end else begin
                    bfly_d = bfly_q + KW'(1);
                end
            end
            StDrain: begin
                if (stage_q == SW'(LOG2 - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                    stage_d = stage_q + SW'(1);
                    bfly_d  = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                stage_d = '0;
                bfly_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Addresses are computed from the next (stage, butterfly) so they appear
    // registered in the same cycle the FSM is in RUN for that butterfly.
    always_comb begin
        span   = LOG2'(1) << stage_d;
        pos    = LOG2'(bfly_d) & (span - LOG2'(1));
        grp    = LOG2'(bfly_d) >> stage_d;
        addr_a = ((grp << stage_d) << 1) | pos;

        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        tw_addr_d   = tw_addr_q;
        if (state_d == StRun) begin
            rd_addr_a_d = addr_a;
            rd_addr_b_d = addr_a | span;
            tw_addr_d   = KW'(pos) << (SW'(LOG2 - 1) - stage_d);
        end

        busy_d      = (state_d == StRun) || (state_d == StDrain);
        done_d      = (state_d == StDone);
        // Read data returns one cycle after issue; write back in that cycle.
        wr_en_d     = (state_q == StRun);
        wr_addr_a_d = rd_addr_a_q;
        wr_addr_b_d = rd_addr_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            bfly_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;

    assign bf_in1 = rd_data_a;
    assign bf_in2 = rd_data_b;
    assign bf_tw  = tw_data;

`ifdef FFT_SCALE_EN
    assign wr_data_a = {bf_out1[WIDTH-1], bf_out1[WIDTH-1:HW+1],
                        bf_out1[HW-1],    bf_out1[HW-1:1]};
    assign wr_data_b = {bf_out2[WIDTH-1], bf_out2[WIDTH-1:HW+1],
                        bf_out2[HW-1],    bf_out2[HW-1:1]};
`else
    assign wr_data_a = bf_out1;
    assign wr_data_b = bf_out2;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: behavioural RAM/ROM/butterfly plus a
// textbook in-place FFT reference model feeding an expected-write queue.
module tb_fft_stage_sequencer;

    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         busy, done, wr_en;
    logic [2:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0]   tw_addr;
    logic [W-1:0] rd_data_a, rd_data_b, tw_data;
    logic [W-1:0] bf_in1, bf_in2, bf_tw, bf_out1, bf_out2, wr_data_a, wr_data_b;

    fft_stage_sequencer #(.SAMPLES(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .tw_addr   (tw_addr),
        .tw_data   (tw_data),
        .bf_in1    (bf_in1),
        .bf_in2    (bf_in2),
        .bf_tw     (bf_tw),
        .bf_out1   (bf_out1),
        .bf_out2   (bf_out2),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endfunction

    // Complex butterfly on Q7 twiddles, 8-bit halves: returns {out2, out1}.
    function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] w);
        int ar, ai, br, bi, wr, wi, pr, pi;
        logic [7:0] o1r, o1i, o2r, o2i;
        ar = int'($signed(a[7:0]));  ai = int'($signed(a[15:8]));
        br = int'($signed(b[7:0]));  bi = int'($signed(b[15:8]));
        wr = int'($signed(w[7:0]));  wi = int'($signed(w[15:8]));
        pr = (br * wr - bi * wi) >>> 7;
        pi = (br * wi + bi * wr) >>> 7;
        o1r = 8'(ar + pr);  o1i = 8'(ai + pi);
        o2r = 8'(ar - pr);  o2i = 8'(ai - pi);
        return {o2i, o2r, o1i, o1r};
    endfunction

    function automatic logic [15:0] scl(input logic [15:0] x);
`ifdef FFT_SCALE_EN
        logic signed [7:0] re, im;
        re = $signed(x[7:0]) >>> 1;
        im = $signed(x[15:8]) >>> 1;
        return {im, re};
`else
        return x;
`endif
    endfunction

    assign {bf_out2, bf_out1} = bfly(bf_in1, bf_in2, bf_tw);

    // Behavioural dual-port RAM and twiddle ROM, both with 1-cycle read latency.
    logic [W-1:0] ram    [N];
    logic [W-1:0] img    [N];
    logic [W-1:0] tw_rom [N/2];
    logic         ld_go;
    logic [2:0]   ra_lat, rb_lat;
    logic [1:0]   tw_lat;

    always @(posedge clk) begin
        if (ld_go) begin
            for (int i = 0; i < N; i++) ram[i] <= img[i];
        end else if (wr_en) begin
            ram[wr_addr_a] <= wr_data_a;
            ram[wr_addr_b] <= wr_data_b;
        end
        rd_data_a <= ram[rd_addr_a];
        rd_data_b <= ram[rd_addr_b];
        tw_data   <= tw_rom[tw_addr];
        ra_lat    <= rd_addr_a;
        rb_lat    <= rd_addr_b;
        tw_lat    <= tw_addr;
    end

    typedef struct {
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [1:0]  tw;
        logic [15:0] da;
        logic [15:0] db;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mdl [N];

    // Monitor: every write the DUT presents is matched against the next expected butterfly.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got write to %0d/%0d expected none",
                         wr_addr_a, wr_addr_b);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_addr_a", ra_lat, e.ra);
                chk("rd_addr_b", rb_lat, e.rb);
                chk("tw_addr", tw_lat, e.tw);
                chk("wr_addr_a", wr_addr_a, e.ra);
                chk("wr_addr_b", wr_addr_b, e.rb);
                chk("wr_data_a", wr_data_a, e.da);
                chk("wr_data_b", wr_data_b, e.db);
            end
        end
    end

    // Load RAM/ROM and build the expected butterfly stream from a textbook in-place FFT.
    task automatic prep(input int mode);
        exp_t        e;
        logic [31:0] r;
        for (int i = 0; i < N; i++) begin
            if (mode == 1) img[i] = (i == 0) ? 16'h0040 : 16'h0000;
            else           img[i] = 16'($urandom);
            mdl[i] = img[i];
        end
        for (int i = 0; i < N / 2; i++) tw_rom[i] = 16'($urandom);
        for (int s = 0; s < 3; s++) begin
            int span;
            span = 1 << s;
            for (int g = 0; g < N; g += 2 * span) begin
                for (int p = 0; p < span; p++) begin
                    e.ra = 3'(g + p);
                    e.rb = 3'(g + p + span);
                    e.tw = 2'(p * (N / (2 * span)));
                    r    = bfly(mdl[g + p], mdl[g + p + span], tw_rom[p * (N / (2 * span))]);
                    e.da = scl(r[15:0]);
                    e.db = scl(r[31:16]);
                    mdl[g + p]        = e.da;
                    mdl[g + p + span] = e.db;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        ld_go = 1'b1;
        @(negedge clk);
        ld_go = 1'b0;
    endtask

    // Called with start already high ahead of the first edge.
    task automatic observe(input bit noise);
        int busy_cnt = 0;
        int done_at  = 0;
        int done_cnt = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("run_entered", {31'b0, busy}, 1);
                chk("first_rd_a", {29'b0, rd_addr_a}, 0);
                chk("first_rd_b", {29'b0, rd_addr_b}, 1);
            end
            chk("wr_en_pattern", {31'b0, wr_en},
                (n >= 2 && n <= 15 && ((n - 1) % 5) != 0) ? 1 : 0);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (noise && n <= 16) start = (n == 16) ? 1'b1 : 1'($urandom_range(0, 1));
            else                  start = 1'b0;
        end
        chk("busy_cycles", busy_cnt, 15);
        chk("done_cycle", done_at, 16);
        chk("done_pulses", done_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_ram(input int mode);
        for (int i = 0; i < N; i++) begin
            chk("final_ram", ram[i], mdl[i]);
            if (mode == 1) begin
`ifdef FFT_SCALE_EN
                chk("impulse_word", ram[i], 16'h0008);
`else
                chk("impulse_word", ram[i], 16'h0040);
`endif
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_wr_en"}, {31'b0, wr_en}, 0);
        chk({tag, "_rd_a"}, {29'b0, rd_addr_a}, 0);
        chk({tag, "_rd_b"}, {29'b0, rd_addr_b}, 0);
        chk({tag, "_tw"}, {30'b0, tw_addr}, 0);
        chk({tag, "_wr_a"}, {29'b0, wr_addr_a}, 0);
        chk({tag, "_wr_b"}, {29'b0, wr_addr_b}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        ld_go = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        prep(0);
        @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;
        observe(1'b0);
        check_ram(0);

        prep(1);
        start = 1'b1;
        observe(1'b0);
        check_ram(1);

        for (int t = 0; t < 2; t++) begin
            prep(0);
            start = 1'b1;
            observe(1'b1);
            check_ram(0);
        end

        // Abort mid-stage 1, then a clean transform.
        prep(0);
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 0);
            chk("abort_no_busy", {31'b0, busy}, 0);
        end
        exp_q.delete();
        rst_n = 1'b1;
        prep(0);
        start = 1'b1;
        observe(1'b0);
        check_ram(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
